// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} state_t;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // The count must be able to reach MAX_BURST itself, hence the +1.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side signal bundle of the arbiter; master is the arbiter itself.
interface fifo_wr_arbiter_if import fifo_arb_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_W       = id_width(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_REQ-1:0]            ack_o;
  logic                          full_i;
  logic                          wr_en_o;
  logic [DATA_WIDTH-1:0]         wdata_o;
  logic                          busy_o;
  logic [ID_W-1:0]               owner_o;

  modport master (
    input  req_i, wdata_i, full_i,
    output ack_o, wr_en_o, wdata_o, busy_o, owner_o
  );

  modport slave (
    output req_i, wdata_i, full_i,
    input  ack_o, wr_en_o, wdata_o, busy_o, owner_o
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin winner search starting just after the last owner.
module rr_pick import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               valid,
  output logic [ID_W-1:0]    winner
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] mask;
  logic [2*NUM_REQ-1:0] cand;

  // Doubling the vector turns the wrap-around search into a linear window last+1 .. last+NUM_REQ.
  always_comb begin
    dbl = {req, req};
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      mask[i] = (i > int'(last)) && (i <= int'(last) + NUM_REQ);
    end
    cand   = dbl & mask;
    valid  = |cand;
    winner = '0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (cand[i]) winner = ID_W'(i % NUM_REQ);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharing of one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = id_width(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int              CNT_W   = cnt_width(MAX_BURST);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_t            state;
  logic [ID_W-1:0]   owner;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_inc;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic              owner_req;
  logic              beat;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (bus.req_i),
    .last   (owner),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  assign owner_req = bus.req_i[owner];
  assign count_inc = count + CNT_W'(1);

  // A beat never fires while full or during the reset cycle, so the FIFO cannot overflow.
  assign beat = !rst && (state == BURST) && owner_req && !bus.full_i;

  always_comb begin
    bus.ack_o        = '0;
    bus.ack_o[owner] = beat;
  end

  assign bus.wr_en_o = beat;
  assign bus.wdata_o = beat ? bus.wdata_i[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.busy_o  = (state == BURST);
  assign bus.owner_o = owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= LAST_ID;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_id;
            count <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          // A full stall holds both the count and the grant.
          if (beat) begin
            count <= count_inc;
            if (count_inc == CNT_MAX) state <= IDLE;
          end else if (!owner_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised scoreboard bench for fifo_wr_arbiter against a rule-level reference model.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int MEM        = 256;

  typedef struct packed {
    logic [NUM_REQ-1:0]    ack;
    logic                  wr;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;
    logic [1:0]            owner;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_WIDTH-1:0] prod_mem [NUM_REQ][MEM];
  int   head [NUM_REQ];
  int   tail [NUM_REQ];

  int   m_owner;
  int   m_count;
  bit   m_burst;

  exp_t exp_q [$];
  int   compared;
  int   mismatched;
  bit   fifo_mode;
  int   fifo_occ;
  int   dut_writes;

  task automatic push_beat(input int k, input logic [DATA_WIDTH-1:0] d);
    if (tail[k] < MEM) begin
      prod_mem[k][tail[k]] = d;
      tail[k]++;
    end
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = !m_burst;
    for (int k = 0; k < NUM_REQ; k++) if (head[k] < tail[k]) idle = 1'b0;
    return idle;
  endfunction

  // One clock of stimulus; the expected outputs for that clock are queued, then the model steps.
  task automatic applyStimulus(input bit r, input bit f_rand);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] wd;
    logic                          full;
    exp_t                          e;
    bit                            found;
    int                            c;
    @(posedge clk);
    #1;
    wd = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req[k] = head[k] < tail[k];
      if (req[k]) wd[k*DATA_WIDTH +: DATA_WIDTH] = prod_mem[k][head[k]];
    end
    full = fifo_mode ? (fifo_occ >= FIFO_DEPTH) : f_rand;
    rst         = r;
    bus.req_i   = req;
    bus.wdata_i = wd;
    bus.full_i  = full;

    e       = '0;
    e.busy  = m_burst;
    e.owner = 2'(m_owner);
    if (!r && m_burst && req[m_owner] && !full) begin
      e.ack[m_owner] = 1'b1;
      e.wr           = 1'b1;
      e.data         = prod_mem[m_owner][head[m_owner]];
    end
    exp_q.push_back(e);

    if (e.wr) begin
      head[m_owner]++;
      if (fifo_mode) fifo_occ++;
    end
    if (r) begin
      m_burst = 1'b0;
      m_owner = NUM_REQ - 1;
      m_count = 0;
    end else if (!m_burst) begin
      found = 1'b0;
      for (int d = 1; d <= NUM_REQ; d++) begin
        c = (m_owner + d) % NUM_REQ;
        if (!found && req[c]) begin
          found   = 1'b1;
          m_owner = c;
        end
      end
      if (found) begin
        m_count = 0;
        m_burst = 1'b1;
      end
    end else if (e.wr) begin
      m_count++;
      if (m_count == MAX_BURST) m_burst = 1'b0;
    end else if (!req[m_owner]) begin
      m_burst = 1'b0;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t act;
    act.ack   = bus.ack_o;
    act.wr    = bus.wr_en_o;
    act.data  = bus.wdata_o;
    act.busy  = bus.busy_o;
    act.owner = bus.owner_o;
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("[TB] FAIL outputs @%0t: ack=%b wr=%b data=%h busy=%b owner=%0d, want ack=%b wr=%b data=%h busy=%b owner=%0d",
               $time, act.ack, act.wr, act.data, act.busy, act.owner,
               e.ack, e.wr, e.data, e.busy, e.owner);
    end
    compared++;
    if ((act.wr !== (|act.ack)) || ($countones(act.ack) > 1) || (act.wr && bus.full_i)) begin
      mismatched++;
      $display("[TB] FAIL protocol @%0t: ack=%b wr=%b full=%b, want one-hot ack matching wr and no write while full",
               $time, act.ack, act.wr, bus.full_i);
    end
    if (fifo_mode && act.wr) dut_writes++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!all_idle() && n < 300) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    compared++;
    if (!all_idle()) begin
      mismatched++;
      $display("[TB] FAIL drain %s: still busy after %0d cycles, want idle", name, n);
    end
  endtask

  initial begin
    int stall;
    bit did_reset;
    rst         = 1'b1;
    bus.req_i   = '0;
    bus.wdata_i = '0;
    bus.full_i  = 1'b0;
    compared    = 0;
    mismatched  = 0;
    fifo_mode   = 1'b0;
    fifo_occ    = 0;
    dut_writes  = 0;
    m_owner     = NUM_REQ - 1;
    m_count     = 0;
    m_burst     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] single requester, two bursts");
    for (int i = 0; i < 8; i++) push_beat(0, 8'hA0 + 8'(i));
    drain("single");

    $display("[TB] all requesters, rotation");
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < NUM_REQ; k++) push_beat(k, {4'(k), 4'(i)});
    drain("rotation");

    $display("[TB] full stall on owner 2");
    for (int i = 0; i < 4; i++) push_beat(2, 8'h20 + 8'(i));
    push_beat(3, 8'h3F);
    stall = 5;
    for (int n = 0; n < 30; n++) begin
      if (m_burst && m_owner == 2 && m_count == 2 && stall > 0) begin
        stall--;
        applyStimulus(1'b0, 1'b1);
      end else begin
        applyStimulus(1'b0, 1'b0);
      end
    end
    drain("stall");

    $display("[TB] owner 1 drops early");
    push_beat(1, 8'h10);
    push_beat(1, 8'h11);
    for (int i = 0; i < 4; i++) push_beat(3, 8'h30 + 8'(i));
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int k = 1; k < NUM_REQ; k++) push_beat(k, 8'h50 + 8'(k));
    drain("drop");

    $display("[TB] reset mid-burst");
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < NUM_REQ; k++) push_beat(k, {4'(k + 8), 4'(i)});
    did_reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!did_reset && m_burst && m_count == 1 && head[m_owner] < tail[m_owner]) begin
        did_reset = 1'b1;
        applyStimulus(1'b1, 1'b0);
      end else begin
        applyStimulus(1'b0, 1'b0);
      end
    end
    drain("reset");

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      int k;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, NUM_REQ - 1);
        if (tail[k] - head[k] < 6) push_beat(k, 8'($urandom));
      end
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0);
    end
    drain("random");

    $display("[TB] 16-deep FIFO with idle reader");
    fifo_mode  = 1'b1;
    fifo_occ   = 0;
    dut_writes = 0;
    for (int i = 0; i < 20; i++)
      for (int k = 0; k < 3; k++) push_beat(k, {4'(k + 4), 4'(i)});
    for (int n = 0; n < 120; n++) applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (dut_writes != FIFO_DEPTH) begin
      mismatched++;
      $display("[TB] FAIL fifo_writes: got %0d writes, want %0d", dut_writes, FIFO_DEPTH);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one synchronous FIFO among NUM_REQ requesters.
- Arbitration is round-robin, with a bounded burst lock so that each grant transfers up to MAX_BURST consecutive beats.
- Sits between the producer blocks and the FIFO's wr_en_i/wdata_i/full_o interface.
- Guarantees that no write is issued while the FIFO reports full, so the FIFO's overflow_o never asserts due to this block.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 8, width of one data beat; must match the FIFO.
- MAX_BURST, 4, maximum beats per grant (≥1).
- ID_W, $clog2(NUM_REQ), width of the requester index (derived).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous reset, active-high.
- req_i  in  NUM_REQ  per-requester "beat available"; bit k belongs to requester k.
- wdata_i  in  NUM_REQ*DATA_WIDTH  flattened data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- ack_o  out  NUM_REQ  one-hot; a beat is consumed from requester k this cycle.
- full_i  in  1  FIFO full flag (FIFO full_o).
- wr_en_o  out  1  FIFO write enable (FIFO wr_en_i).
- wdata_o  out  DATA_WIDTH  FIFO write data (FIFO wdata_i).
- busy_o  out  1  high while a grant is held (state BURST).
- owner_o  out  ID_W  index of the current or most recent owner.

Behaviour:
- Reset values:
  - state=IDLE, owner_o=NUM_REQ-1 (so requester 0 wins first), burst count=0.
  - ack_o=0, wr_en_o=0, wdata_o=0, busy_o=0.
- Reset mid-burst: in the next cycle all outputs return to their reset values and the in-flight grant is abandoned. No ack or write is issued in the reset cycle.
- State IDLE:
  - ack_o=0, wr_en_o=0, wdata_o=0.
  - If |req_i, pick the first set bit searching owner_o+1, owner_o+2, … modulo NUM_REQ. Load owner_o, clear the count, and go to BURST.
  - full_i does not block granting.
  - With no request, stay in IDLE.
- State BURST, with k=owner_o:
  - beat = req_i[k] && !full_i.
  - ack_o[k]=beat, wr_en_o=beat, wdata_o = beat ? wdata_i slice k : 0. These are combinational, with zero latency to the FIFO.
  - On a beat, count increments.
  - Go to IDLE when the beat makes count==MAX_BURST, or when req_i[k]==0 (no beat that cycle).
  - If full_i and req_i[k]: stall. Stay in BURST, hold count, issue no write.
- Latency: one IDLE arbitration cycle precedes every burst. A requester holding req_i continuously receives its first ack one cycle after the request is sampled in IDLE.
- Throughput/fairness: the owner rotates after each burst, so the worst-case wait for a requester is (NUM_REQ-1)*(MAX_BURST+1) cycles plus full stalls.
- Requests from non-owners are ignored during BURST. Requesters hold req_i and data stable until acked.
- ack_o is always one-hot or zero, and wr_en_o == |ack_o.
- The count is $clog2(MAX_BURST+1) bits wide and never wraps.
- owner_o wraps from NUM_REQ-1 to 0.

Decomposition:
- Shared package fifo_arb_pkg: state enum {IDLE, BURST} and the ID_W/count-width helper functions.
- Sub-module rr_pick: combinational, inputs req vector and last index, outputs valid and winner index. Implemented with a double-width masked priority search.
- The top-level module holds the FSM, count, muxing and the FIFO interface.

Test Plan:
- Reset, then req_i=4'b0001 held with data 8'hA0..A7 → first ack_o one cycle after the request is sampled. Four beats A0–A3 are written on consecutive cycles, then one IDLE cycle, then beats A4–A7.
- req_i=4'b1111 held, full_i=0 → owner sequence 0,1,2,3,0. Each owner gets exactly 4 beats with one gap cycle between bursts, and ack_o is never multi-hot.
- Owner 2 in BURST, full_i forced 1 for 5 cycles after beat 2 → wr_en_o=0 and count held during the stall. After release, beats 3–4 complete with no overflow, then grant moves to 3.
- Owner 1 drops req_i after 2 beats while req_i[3]=1 → return to IDLE, then grant to 3. A later request from 1 waits behind 2 and 3 if they are requesting.
- rst asserted during beat 2 of a burst → next cycle wr_en_o=0, busy_o=0, owner_o=3. The following grant goes to requester 0 when all are requesting.
- Integration with the 16-deep FIFO, 3 requesters sending 20 beats each while the reader stays idle → exactly 16 writes. full_o holds and overflow_o never asserts; data order within each requester is preserved.
